// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: width helpers shared by the priority /
// round-robin arbiter and its winner-select logic.
package prio_arb_pkg;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int ch_width(input int n_ch);
      return clog2_min1(n_ch);
   endfunction

   // AGE_LIMIT = 0 disables ageing but still needs a legal 1-bit counter
   function automatic int age_width(input int age_limit);
      return clog2_min1(age_limit + 1);
   endfunction

endpackage

// File: rtl/prio_rr_pick.sv
// prio_rr_pick: combinational winner select. Promoted class first,
// then highest priority, then first channel at/after rr_ptr.
module prio_rr_pick
   import prio_arb_pkg::*;
#(
   parameter int N_CH    = 8,
   parameter int PRIO_W  = 3,
   parameter bit RR_ONLY = 1'b0,
   parameter int CH_W    = ch_width(N_CH)
) (
   input  logic [N_CH-1:0]        cand_i,
   input  logic [N_CH-1:0]        promo_i,
   input  logic [N_CH*PRIO_W-1:0] prio_i,
   input  logic [CH_W-1:0]        rr_ptr_i,
   output logic [N_CH-1:0]        gnt_o,
   output logic [CH_W-1:0]        idx_o,
   output logic                   any_o
);

   logic [N_CH-1:0]   promo_c;
   logic [N_CH-1:0]   cls_mask;
   logic [N_CH-1:0]   top_mask;
   logic [PRIO_W-1:0] max_prio;
   logic              found;
   int                j;

   always_comb begin
      promo_c  = cand_i & promo_i;
      cls_mask = (|promo_c) ? promo_c : cand_i;

      max_prio = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (cls_mask[i] && (prio_i[i*PRIO_W +: PRIO_W] > max_prio))
            max_prio = prio_i[i*PRIO_W +: PRIO_W];
      end

      top_mask = cls_mask;
      if (!RR_ONLY) begin
         for (int i = 0; i < N_CH; i++) begin
            if (prio_i[i*PRIO_W +: PRIO_W] != max_prio)
               top_mask[i] = 1'b0;
         end
      end

      // rotate the scan so rr_ptr is examined first
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N_CH; k++) begin
         j = int'(rr_ptr_i) + k;
         if (j >= N_CH)
            j = j - N_CH;
         if (!found && top_mask[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = CH_W'(j);
         end
      end

      any_o = |cand_i;
   end

endmodule

// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter: N-channel valid/ready merge with priority, round-robin
// tie-break, age promotion and a registered output stage.
module prio_rr_arbiter
   import prio_arb_pkg::*;
#(
   parameter int N_CH      = 8,
   parameter int DATA_W    = 32,
   parameter int PRIO_W    = 3,
   parameter int AGE_LIMIT = 16,
   parameter bit RR_ONLY   = 1'b0,
   localparam int CH_W     = ch_width(N_CH),
   localparam int AGE_W    = age_width(AGE_LIMIT)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CH-1:0]        valid_i,
   input  logic [N_CH*DATA_W-1:0] data_i,
   input  logic [N_CH*PRIO_W-1:0] prio_i,
   output logic [N_CH-1:0]        ready_i,
   output logic [DATA_W-1:0]      data_o,
   output logic                   valid_o,
   output logic [CH_W-1:0]        grant_o,
   input  logic                   ready_o
);

   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

   logic              load;
   logic              take;
   logic              any_req;
   logic [N_CH-1:0]   promo;
   logic [N_CH-1:0]   gnt;
   logic [CH_W-1:0]   win_idx;
   logic [DATA_W-1:0] win_data;

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [AGE_W-1:0]  age_q [N_CH];
   logic [AGE_W-1:0]  age_d [N_CH];

   assign load    = !valid_q || ready_o;
   assign take    = load && any_req && !reset;
   assign ready_i = take ? gnt : '0;

   always_comb begin
      promo = '0;
      for (int i = 0; i < N_CH; i++)
         promo[i] = (AGE_LIMIT != 0) && (age_q[i] == AGE_MAX);
   end

   prio_rr_pick #(
      .N_CH    (N_CH),
      .PRIO_W  (PRIO_W),
      .RR_ONLY (RR_ONLY),
      .CH_W    (CH_W)
   ) u_pick (
      .cand_i   (valid_i),
      .promo_i  (promo),
      .prio_i   (prio_i),
      .rr_ptr_i (rr_ptr_q),
      .gnt_o    (gnt),
      .idx_o    (win_idx),
      .any_o    (any_req)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < N_CH; i++)
         if (gnt[i])
            win_data = data_i[i*DATA_W +: DATA_W];
   end

   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      if (load) begin
         valid_d = any_req;
         if (any_req) begin
            data_d   = win_data;
            grant_d  = win_idx;
            rr_ptr_d = (int'(win_idx) == N_CH - 1) ? '0 : win_idx + 1'b1;
         end
      end

      // stalled waiters keep ageing; dropping valid forgets the wait
      for (int i = 0; i < N_CH; i++) begin
         if (!valid_i[i])
            age_d[i] = '0;
         else if (take && gnt[i])
            age_d[i] = '0;
         else if (age_q[i] < AGE_MAX)
            age_d[i] = age_q[i] + 1'b1;
         else
            age_d[i] = age_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         for (int i = 0; i < N_CH; i++)
            age_q[i] <= '0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         age_q    <= age_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign grant_o = grant_q;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// tb_prio_rr_arbiter: directed vectors with a scoreboard queue per DUT;
// monitors compare whenever an output beat is accepted.
module tb_prio_rr_arbiter;

   typedef struct packed {
      logic [2:0]  g;
      logic [31:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [7:0]   va, vb;
   logic [2:0]   pa [8];
   logic [2:0]   pb [8];
   logic [31:0]  da [8];
   logic [31:0]  db [8];
   logic [255:0] dfa, dfb;
   logic [23:0]  pfa, pfb;
   logic [7:0]   ra, rb;
   logic [31:0]  doa, dob;
   logic         vo_a, vo_b;
   logic [2:0]   ga, gb;
   logic         rdy_a, rdy_b;

   exp_t qa[$];
   exp_t qb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always_comb begin
      dfa = '0;
      dfb = '0;
      pfa = '0;
      pfb = '0;
      for (int i = 0; i < 8; i++) begin
         dfa[i*32 +: 32] = da[i];
         dfb[i*32 +: 32] = db[i];
         pfa[i*3 +: 3]   = pa[i];
         pfb[i*3 +: 3]   = pb[i];
      end
   end

   prio_rr_arbiter #(
      .N_CH(8), .DATA_W(32), .PRIO_W(3), .AGE_LIMIT(4), .RR_ONLY(1'b0)
   ) dut_a (
      .clk(clk), .reset(reset), .valid_i(va), .data_i(dfa),
      .prio_i(pfa), .ready_i(ra), .data_o(doa), .valid_o(vo_a),
      .grant_o(ga), .ready_o(rdy_a)
   );

   prio_rr_arbiter #(
      .N_CH(8), .DATA_W(32), .PRIO_W(3), .AGE_LIMIT(16), .RR_ONLY(1'b1)
   ) dut_b (
      .clk(clk), .reset(reset), .valid_i(vb), .data_i(dfb),
      .prio_i(pfb), .ready_i(rb), .data_o(dob), .valid_o(vo_b),
      .grant_o(gb), .ready_o(rdy_b)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic push_a(input int c);
      exp_t e;
      e.g = 3'(c);
      e.d = da[c];
      qa.push_back(e);
   endtask

   task automatic push_b(input int c);
      exp_t e;
      e.g = 3'(c);
      e.d = db[c];
      qb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && vo_a && rdy_a) begin
         if (qa.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_a: unexpected beat grant %0d data %h", ga, doa);
         end else begin
            e = qa.pop_front();
            chk("sb_a grant", 32'(ga), 32'(e.g));
            chk("sb_a data", doa, e.d);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && vo_b && rdy_b) begin
         if (qb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_b: unexpected beat grant %0d data %h", gb, dob);
         end else begin
            e = qb.pop_front();
            chk("sb_b grant", 32'(gb), 32'(e.g));
            chk("sb_b data", dob, e.d);
         end
      end
   end

   initial begin
      reset = 1'b1;
      rdy_a = 1'b1;
      rdy_b = 1'b1;
      vb    = '0;
      for (int i = 0; i < 8; i++) begin
         pa[i] = 3'((i * 3) % 8);
         pb[i] = '0;
         da[i] = 32'hA000_0000 + 32'(i);
         db[i] = 32'hB000_0000 + 32'(i);
      end
      va = 8'hFF;

      // reset held with every channel requesting; ch5 has prio 7
      repeat (3) begin
         @(negedge clk);
         chk("rst ready_i", 32'(ra), 32'h0);
         chk("rst valid_o", 32'(vo_a), 32'h0);
         tick();
      end
      chk("rst data_o", doa, 32'h0);
      chk("rst grant_o", 32'(ga), 32'h0);
      push_a(5);
      reset = 1'b0;
      @(negedge clk);
      chk("first grant ready_i", 32'(ra), 32'h20);
      tick();
      va = '0;
      repeat (2) tick();

      // strict priority: ch6 (7) over ch2 (5)
      pa[2] = 3'd5;
      pa[6] = 3'd7;
      va    = 8'h44;
      push_a(6);
      push_a(2);
      @(negedge clk);
      chk("prio ready_i ch6", 32'(ra), 32'h40);
      tick();
      va[6] = 1'b0;
      @(negedge clk);
      chk("prio ready_i ch2", 32'(ra), 32'h04);
      tick();
      va = '0;
      repeat (2) tick();

      // round-robin tie across all channels
      pulse_reset();
      for (int i = 0; i < 8; i++)
         pa[i] = 3'd3;
      va = 8'hFF;
      for (int k = 0; k < 16; k++)
         push_a(k % 8);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("rr ready_i", 32'(ra), 32'h1 << (k % 8));
         tick();
      end
      va = '0;
      repeat (2) tick();

      // ageing: ch1 (prio 0) promoted every 5th arbitration
      pulse_reset();
      pa[0] = 3'd7;
      pa[1] = 3'd0;
      va    = 8'h03;
      for (int k = 0; k < 10; k++)
         push_a((k % 5 == 4) ? 1 : 0);
      repeat (10) tick();
      va = '0;
      repeat (2) tick();

      // backpressure: hold A5 for 5 cycles while ch2 ages out
      pulse_reset();
      da[0] = 32'hA5A5_A5A5;
      pa[0] = 3'd1;
      va    = 8'h01;
      push_a(0);
      @(negedge clk);
      chk("bp load ready_i", 32'(ra), 32'h01);
      tick();
      rdy_a = 1'b0;
      va    = 8'h04;
      pa[2] = 3'd0;
      pa[3] = 3'd7;
      push_a(2);
      push_a(3);
      for (int s = 1; s <= 5; s++) begin
         if (s == 5)
            va[3] = 1'b1;
         @(negedge clk);
         chk("bp ready_i", 32'(ra), 32'h0);
         chk("bp valid_o", 32'(vo_a), 32'h1);
         chk("bp data_o", doa, 32'hA5A5_A5A5);
         chk("bp grant_o", 32'(ga), 32'h0);
         tick();
      end
      rdy_a = 1'b1;
      @(negedge clk);
      chk("bp release ready_i", 32'(ra), 32'h04);
      tick();
      va[2] = 1'b0;
      @(negedge clk);
      chk("bp next ready_i", 32'(ra), 32'h08);
      tick();
      va = '0;
      repeat (2) tick();

      // RR_ONLY: ptr at 4 picks ch4 (prio 0) over ch3 (prio 7)
      pulse_reset();
      pb[3] = 3'd7;
      pb[4] = 3'd0;
      vb    = 8'h08;
      push_b(3);
      @(negedge clk);
      chk("rronly ready_i ch3", 32'(rb), 32'h08);
      tick();
      vb = 8'h18;
      push_b(4);
      push_b(3);
      @(negedge clk);
      chk("rronly ready_i ch4", 32'(rb), 32'h10);
      tick();
      vb[4] = 1'b0;
      @(negedge clk);
      chk("rronly ready_i ch3b", 32'(rb), 32'h08);
      tick();
      vb = '0;
      repeat (3) tick();

      chk("sb_a drained", 32'(qa.size()), 32'h0);
      chk("sb_b drained", 32'(qb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
